// File: rtl/xsim_host_bridge_if.sv
// Host request/response channel between the simulation host and the bridge.
// The master side is the host and the slave side is xsim_host_bridge.
interface xsim_host_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/xsim_host_bridge.sv
// Host bridge: serialises host words into portal register accesses.
// Define WRITE_ACK_EN to return an acknowledge word for every write.
module xsim_host_bridge #(
    parameter int NUM_PORTALS     = 4,
    parameter int REGS_PER_PORTAL = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    xsim_host_bridge_if.slave      bus,
    output logic [NUM_PORTALS-1:0] irq,
    output logic                   finish_req,
    output logic [31:0]            cycle_count
);
    localparam int PW = (NUM_PORTALS > 1) ? $clog2(NUM_PORTALS) : 1;
    localparam int RW = $clog2(REGS_PER_PORTAL);

    typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] hdr_q, hdr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        finish_req_q, finish_req_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] mem_q [NUM_PORTALS][REGS_PER_PORTAL];
    logic [31:0] mem_d [NUM_PORTALS][REGS_PER_PORTAL];

    logic [7:0]  rd_pid, rd_idx, wr_pid, wr_idx;
    logic [31:0] rd_val;
    logic        unused_hdr;

    function automatic logic in_map(input logic [7:0] pid, input logic [7:0] idx);
        return (int'(pid) < NUM_PORTALS) && (int'(idx) < REGS_PER_PORTAL);
    endfunction

    assign rd_pid = bus.req_data[15:8];
    assign rd_idx = bus.req_data[7:0];
    assign wr_pid = hdr_q[15:8];
    assign wr_idx = hdr_q[7:0];
    assign unused_hdr = &{1'b0, hdr_q[30:16], bus.req_data[30:16]};

    always_comb begin
        rd_val = 32'hDEADBEEF;
        if (rd_pid == 8'hFF) begin
            if (rd_idx == 8'd0)
                rd_val = cycle_count_q;
            else if (rd_idx == 8'd1)
                rd_val = {31'b0, finish_req_q};
        end else if (in_map(rd_pid, rd_idx)) begin
            unique case (rd_idx)
                8'd0:    rd_val = {16'hC0DE, 8'h00, rd_pid};
                8'd3:    rd_val = 32'h0;
                default: rd_val = mem_q[rd_pid[PW-1:0]][rd_idx[RW-1:0]];
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        finish_req_d  = finish_req_q;
        cycle_count_d = cycle_count_q + 32'd1;
        mem_d         = mem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    hdr_d = bus.req_data;
                    if (bus.req_data[31]) begin
                        state_d = WDATA;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rd_val;
                    end
                end
            end
            WDATA: begin
                if (bus.req_valid) begin
                    if (wr_pid == 8'hFF) begin
                        if (wr_idx == 8'd1 && bus.req_data != 32'h0)
                            finish_req_d = 1'b1;
                    end else if (in_map(wr_pid, wr_idx)) begin
                        // reg1 is W1C status, reg3 ORs into status
                        unique case (wr_idx)
                            8'd0: ;
                            8'd1: mem_d[wr_pid[PW-1:0]][1] =
                                      mem_q[wr_pid[PW-1:0]][1] & ~bus.req_data;
                            8'd3: mem_d[wr_pid[PW-1:0]][1] =
                                      mem_q[wr_pid[PW-1:0]][1] | bus.req_data;
                            default: mem_d[wr_pid[PW-1:0]][wr_idx[RW-1:0]] =
                                      bus.req_data;
                        endcase
                    end
`ifdef WRITE_ACK_EN
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = hdr_q | 32'h4000_0000;
`else
                    state_d     = IDLE;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            hdr_q         <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'h0;
            finish_req_q  <= 1'b0;
            cycle_count_q <= 32'h0;
            for (int p = 0; p < NUM_PORTALS; p++)
                for (int r = 0; r < REGS_PER_PORTAL; r++)
                    mem_q[p][r] <= 32'h0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            finish_req_q  <= finish_req_d;
            cycle_count_q <= cycle_count_d;
            mem_q         <= mem_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTALS; p++) begin : g_irq
        assign irq[p] = |(mem_q[p][1] & mem_q[p][2]);
    end

    assign bus.req_ready = (state_q != RESP);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign finish_req    = finish_req_q;
    assign cycle_count   = cycle_count_q;
endmodule

// File: tb/tb_xsim_host_bridge.sv
// Directed bench for xsim_host_bridge: register map, irq, invalid
// accesses, backpressure, mid-write reset and finish request.
module tb_xsim_host_bridge;
    logic        CLK;
    logic        RST_N;
    logic [3:0]  irq;
    logic        finish_req;
    logic [31:0] cycle_count;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] d;
    logic [31:0] held;

    xsim_host_bridge_if bus ();

    xsim_host_bridge #(.NUM_PORTALS(4), .REGS_PER_PORTAL(16)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus.slave),
        .irq         (irq),
        .finish_req  (finish_req),
        .cycle_count (cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge CLK);
        chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_data  = w;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = 32'h0;
    endtask

    task automatic take_rsp(output logic [31:0] v);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        v = bus.rsp_data;
        @(negedge CLK);
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] hdr, output logic [31:0] v);
        send(hdr);
        take_rsp(v);
    endtask

    task automatic wr(input logic [31:0] hdr, input logic [31:0] dat);
        logic [31:0] ack;
        send(hdr);
        send(dat);
`ifdef WRITE_ACK_EN
        take_rsp(ack);
        chk("wr_ack", ack, hdr | 32'h4000_0000);
`else
        ack = 32'h0;
        #1;
        chk("no_ack", {31'b0, bus.rsp_valid}, 32'd0);
`endif
    endtask

    initial begin
        RST_N         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_cycle", cycle_count, 32'h0);
        chk("rst_irq", {28'b0, irq}, 32'h0);
        chk("rst_finish", {31'b0, finish_req}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        repeat (10) @(posedge CLK);
        rd(32'h0000_FF00, d);
        chk("cycle_10_11", {31'b0, (d == 32'd10 || d == 32'd11)}, 32'd1);
        chk("irq_idle", {28'b0, irq}, 32'h0);
        chk("finish_idle", {31'b0, finish_req}, 32'd0);

        rd(32'h0000_0200, d);
        chk("id_p2", d, 32'hC0DE_0002);
        rd(32'h0000_0000, d);
        chk("id_p0", d, 32'hC0DE_0000);
        wr(32'h8000_0205, 32'h1234_5678);
        rd(32'h0000_0205, d);
        chk("scratch_p2", d, 32'h1234_5678);
        rd(32'h0000_0105, d);
        chk("scratch_p1", d, 32'h0);
        wr(32'h8000_020F, 32'hCAFE_F00D);
        rd(32'h0000_020F, d);
        chk("scratch_last", d, 32'hCAFE_F00D);

        wr(32'h8000_0102, 32'h1);
        chk("irq_en_only", {28'b0, irq}, 32'h0);
        wr(32'h8000_0103, 32'h3);
        chk("irq_set", {28'b0, irq}, 32'h2);
        rd(32'h0000_0101, d);
        chk("status_3", d, 32'h3);
        rd(32'h0000_0103, d);
        chk("set_reads_0", d, 32'h0);
        rd(32'h0000_0102, d);
        chk("enable_rd", d, 32'h1);
        wr(32'h8000_0101, 32'h1);
        chk("irq_clr", {28'b0, irq}, 32'h0);
        rd(32'h0000_0101, d);
        chk("status_2", d, 32'h2);

        rd(32'h0000_0900, d);
        chk("inv_portal", d, 32'hDEAD_BEEF);
        rd(32'h0000_0010, d);
        chk("inv_index", d, 32'hDEAD_BEEF);
        rd(32'h0000_FF02, d);
        chk("inv_ctl", d, 32'hDEAD_BEEF);
        wr(32'h8000_0020, 32'hFFFF_FFFF);
        wr(32'h8000_0905, 32'hFFFF_FFFF);
        rd(32'h0000_0205, d);
        chk("inv_wr_nochg", d, 32'h1234_5678);
        rd(32'h0000_0005, d);
        chk("inv_wr_p0", d, 32'h0);
        chk("inv_wr_irq", {28'b0, irq}, 32'h0);

        send(32'h0000_0205);
        held = bus.rsp_data;
        chk("bp_first", held, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.req_valid = 1'b1;
            bus.req_data  = 32'h8000_0206;
            chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_data", bus.rsp_data, held);
            chk("bp_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        @(negedge CLK);
        bus.req_valid = 1'b0;
        take_rsp(d);
        chk("bp_final", d, 32'h1234_5678);
        rd(32'h0000_0206, d);
        chk("bp_ignored", d, 32'h0);

        wr(32'h8000_0307, 32'h5555_AAAA);
        send(32'h8000_0307);
        @(negedge CLK);
        RST_N = 1'b0;
        #2;
        chk("mid_rst_cycle", cycle_count, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        rd(32'h0000_0307, d);
        chk("mid_rst_reg", d, 32'h0);
        rd(32'h0000_0300, d);
        chk("mid_rst_idle", d, 32'hC0DE_0003);

        wr(32'h8000_FF01, 32'h1);
        chk("finish_set", {31'b0, finish_req}, 32'd1);
        wr(32'h8000_FF01, 32'h0);
        chk("finish_sticky", {31'b0, finish_req}, 32'd1);
        rd(32'h0000_FF01, d);
        chk("finish_rd", d, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/xsim_host_bridge.md
Name: xsim_host_bridge

Overview:
- Simulation-top host bridge: single-clock block between the host message channel and a bank of memory-mapped portal register files.
- Host sends 32-bit request words (header, plus data for writes). Block returns read data on a response channel.
- Also drives per-portal interrupts, a free-running cycle counter and a sticky finish request that the simulation top uses to end the run.

Parameters:
- NUM_PORTALS, 4, number of portals (1..16).
- REGS_PER_PORTAL, 16, 32-bit registers per portal (4..256).

Ports:
- CLK  in  1  clock; all state on posedge CLK.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request word valid.
- req_ready  out  1  request word accepted when req_valid & req_ready.
- req_data  in  32  request word.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  32  response word.
- irq  out  NUM_PORTALS  per-portal interrupt, level.
- finish_req  out  1  sticky end-of-simulation request.
- cycle_count  out  32  cycles since reset release.

Behaviour:
- Header word fields: bit31 = write; bits30:16 ignored; bits15:8 = portal id; bits7:0 = register index. Portal id 0xFF selects the control space.
- FSM states are IDLE, WDATA and RESP.
  - IDLE: req_ready=1. On an accepted header, the header is latched. A write goes to WDATA; a read goes to RESP.
  - WDATA: req_ready=1. The next accepted word is the write data. The register updates on that edge. Next state is IDLE.
  - RESP: req_ready=0, rsp_valid=1, rsp_data is held stable until rsp_ready. On handshake, next state is IDLE.
- Read latency: header accepted at edge N gives rsp_valid high from edge N (registered), visible in cycle N+1.
- Portal register map, per portal p:
  - reg0: read-only ID = {16'hC0DE, 8'h00, p[7:0]}.
  - reg1: irq status. Write-1-to-clear.
  - reg2: irq enable. Read/write.
  - reg3: irq set. A write ORs the data into status. Reads return 0.
  - reg4..REGS_PER_PORTAL-1: general read/write.
- Control space (id 0xFF):
  - reg0: cycle_count, read-only.
  - reg1: finish. A write of a nonzero value sets finish_req. Reads return {31'b0, finish_req}.
  - Other indices: invalid.
- Invalid access (portal >= NUM_PORTALS and not 0xFF, or index out of range): writes are ignored; reads return 32'hDEADBEEF.
- irq[p] = |(status[p] & enable[p]). Combinational from registers, so it updates the cycle after the write.
- Simultaneous set and clear on the same status bit cannot occur, because writes are serialized; the later write wins.
- cycle_count: 0 in reset, +1 every clock after, wraps 0xFFFFFFFF to 0.
- finish_req: sticky until reset.
- Reset values:
  - state = IDLE.
  - rsp_valid = 0, rsp_data = 0.
  - All registers = 0; status, enable and irq = 0.
  - finish_req = 0, cycle_count = 0.
- Reset asserted mid-transaction returns to IDLE immediately. A partial write is discarded and a pending response is dropped.
- req_data is ignored when req_ready=0. A stall on rsp_ready holds RESP indefinitely.

Optional Feature:
- WRITE_ACK_EN defined:
  - Each completed write transitions WDATA -> RESP.
  - The response is the latched header word with bit30 forced to 1, including for invalid writes.
- WRITE_ACK_EN undefined:
  - Writes produce no response; WDATA -> IDLE.

Test Plan:
- Reset then 10 idle clocks: read header 0x0000FF00 -> rsp_data = 10 or 11, per cycle_count at capture; irq = 0, finish_req = 0.
- ID and scratch:
  - Read 0x00000200 -> 0xC0DE0002.
  - Write 0x80000205 then data 0x12345678; read 0x00000205 -> 0x12345678.
  - Read portal 1 reg5 -> 0.
- Interrupts on portal 1:
  - Write reg2 = 0x1, then write reg3 = 0x3 -> irq[1] = 1, status reads 0x3.
  - Write reg1 = 0x1 -> irq[1] = 0, status reads 0x2.
- Invalid accesses:
  - Read portal 9 (NUM_PORTALS=4) -> 0xDEADBEEF.
  - Write portal 0 reg 0x20 with REGS_PER_PORTAL=16 -> no state change.
- Backpressure and reset:
  - Hold rsp_ready = 0 for 5 cycles during a read -> rsp_valid and rsp_data stable, req_ready = 0.
  - Assert RST_N = 0 between write header and data -> IDLE, register unchanged.
- Finish and ack:
  - Write 0x8000FF01 data 0x1 -> finish_req = 1 next cycle, stays 1 after a further write of 0.
  - With WRITE_ACK_EN, each write yields response header | 0x40000000.
